// File: rtl/control_sequencer.sv
// control_sequencer: registered micro-step control unit for the CoCC CPU
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   opcode     IR opcode field, decoded in DECODE
//   operand_2  jump-condition select, used in JUMP
//   flag_zero  ALU zero flag
//   flag_carry ALU carry flag
//   mem_ready  RAM handshake; low stretches any step that drives ro or ri
//   irq        level-sensitive interrupt request, masked by ie
//   ctrl       datapath strobes {vo,da,go,halt,si,sd,so,ri,ro,mi,ee,eo,rfo,rfi,cs,co,ci,ii}
//   vec_addr   interrupt handler address, driven onto the bus while vo=1
//   irq_ack    high for the IRQ_VEC step
//   illegal    high for the DECODE step of an undefined opcode
//   state      current micro-step, for debug
module control_sequencer #(
  parameter int OPC_W = 5,
  parameter int SEL_W = 3,
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] IRQ_VECTOR = 8'hF0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OPC_W-1:0]  opcode,
  input  logic [SEL_W-1:0]  operand_2,
  input  logic              flag_zero,
  input  logic              flag_carry,
  input  logic              mem_ready,
  input  logic              irq,
  output logic [19:0]       ctrl,
  output logic [ADDR_W-1:0] vec_addr,
  output logic              irq_ack,
  output logic              illegal,
  output logic [7:0]        state
);
  typedef enum logic [7:0] {
    FETCH_PC   = 8'd0,
    FETCH_INST = 8'd1,
    DECODE     = 8'd2,
    FETCH_OPR  = 8'd3,
    ALU_EXEC   = 8'd4,
    ALU_OUT    = 8'd5,
    LOAD_ADDR  = 8'd6,
    SET_REG    = 8'd7,
    SET_MEM    = 8'd8,
    MOVE_REG   = 8'd9,
    JUMP       = 8'd10,
    FETCH_SP   = 8'd11,
    STACK_REG  = 8'd12,
    INC_SP     = 8'd13,
    RET        = 8'd14,
    MOUT       = 8'd15,
    ROUT       = 8'd16,
    SET_MAR    = 8'd17,
    IRQ_SP     = 8'd18,
    IRQ_PUSH   = 8'd19,
    IRQ_VEC    = 8'd20,
    HALT       = 8'd21
  } state_e;

  localparam logic [19:0] C_II   = 20'h00001;
  localparam logic [19:0] C_CI   = 20'h00002;
  localparam logic [19:0] C_CO   = 20'h00004;
  localparam logic [19:0] C_CS   = 20'h00008;
  localparam logic [19:0] C_RFI  = 20'h00010;
  localparam logic [19:0] C_RFO  = 20'h00020;
  localparam logic [19:0] C_EO   = 20'h00040;
  localparam logic [19:0] C_EE   = 20'h00080;
  localparam logic [19:0] C_MI   = 20'h00100;
  localparam logic [19:0] C_RO   = 20'h00200;
  localparam logic [19:0] C_RI   = 20'h00400;
  localparam logic [19:0] C_SO   = 20'h00800;
  localparam logic [19:0] C_SD   = 20'h01000;
  localparam logic [19:0] C_SI   = 20'h02000;
  localparam logic [19:0] C_HALT = 20'h04000;
  localparam logic [19:0] C_GO   = 20'h08000;
  localparam logic [19:0] C_DA   = 20'h10000;
  localparam logic [19:0] C_VO   = 20'h20000;

  localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_ALU  = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_MOV  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_PUSH = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_RET  = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_MOUT = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_ROUT = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_LDR  = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_EI   = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_DI   = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_HLT  = '1;

  state_e             state_q, state_d;
  logic               ie_q, ie_d, ie_new;
  logic [OPC_W-1:0]   op_q, op_d;
  logic               ja, take_irq, mem_wait;
  state_e             boundary;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH_PC;
      ie_q    <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      op_q    <= op_d;
    end
  end

  // EI/DI update ie in DECODE; the new value already governs the boundary
  // check that ends that same instruction.
  always_comb begin
    ie_new   = (state_q == DECODE && opcode == OP_EI) ? 1'b1 :
               (state_q == DECODE && opcode == OP_DI) ? 1'b0 : ie_q;
    take_irq = irq & ie_new;
    boundary = take_irq ? IRQ_SP : FETCH_PC;
    op_d     = (state_q == DECODE) ? opcode : op_q;
    mem_wait = (ctrl[9] | ctrl[10]) & ~mem_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH_PC:   state_d = FETCH_INST;
      FETCH_INST: state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_ALU:                             state_d = ALU_EXEC;
          OP_LDI, OP_LD, OP_ST, OP_JMP, OP_MOUT: state_d = FETCH_OPR;
          OP_MOV:                             state_d = MOVE_REG;
          OP_PUSH:                            state_d = FETCH_SP;
          OP_RET:                             state_d = INC_SP;
          OP_ROUT:                            state_d = ROUT;
          OP_LDR:                             state_d = SET_MAR;
          OP_HLT:                             state_d = HALT;
          default:                            state_d = boundary;
        endcase
      end
      FETCH_OPR:  state_d = (op_q == OP_LDI) ? SET_REG : (op_q == OP_JMP) ? JUMP : LOAD_ADDR;
      LOAD_ADDR:  state_d = (op_q == OP_LD) ? SET_REG : (op_q == OP_ST) ? SET_MEM : MOUT;
      ALU_EXEC:   state_d = ALU_OUT;
      FETCH_SP:   state_d = (op_q == OP_PUSH) ? STACK_REG : RET;
      INC_SP:     state_d = FETCH_SP;
      SET_MAR:    state_d = SET_REG;
      IRQ_SP:     state_d = IRQ_PUSH;
      IRQ_PUSH:   state_d = IRQ_VEC;
      IRQ_VEC:    state_d = FETCH_PC;
      HALT:       state_d = take_irq ? IRQ_SP : HALT;
      ALU_OUT, SET_REG, SET_MEM, MOVE_REG, JUMP, STACK_REG, RET, MOUT, ROUT:
                  state_d = boundary;
      default:    state_d = FETCH_PC;
    endcase
    if (mem_wait) state_d = state_q;
  end

  always_comb ie_d = (state_q != IRQ_SP && state_d == IRQ_SP) ? 1'b0 : ie_new;

  always_comb
    ja = (operand_2 == SEL_W'(0)) ? 1'b1 :
         (operand_2 == SEL_W'(1)) ? flag_carry :
         (operand_2 == SEL_W'(2)) ? ~flag_carry :
         (operand_2 == SEL_W'(3)) ? flag_zero :
         (operand_2 == SEL_W'(4)) ? ~flag_zero : 1'b0;

  always_comb begin
    ctrl = '0;
    case (state_q)
      FETCH_PC:   ctrl = C_CO | C_MI | C_CI;
      FETCH_INST: ctrl = C_RO | C_II;
      FETCH_OPR:  ctrl = C_CO | C_MI | C_CI;
      ALU_EXEC:   ctrl = C_EE;
      ALU_OUT:    ctrl = C_EO | C_RFI;
      LOAD_ADDR:  ctrl = C_RO | C_MI;
      SET_REG:    ctrl = C_RO | C_RFI;
      SET_MEM:    ctrl = C_RFO | C_RI;
      MOVE_REG:   ctrl = C_RFO | C_RFI;
      JUMP:       ctrl = C_RO | (ja ? (C_CI | C_CS) : '0);
      FETCH_SP:   ctrl = C_SO | C_MI;
      STACK_REG:  ctrl = C_RFO | C_RI | C_SI | C_SD;
      INC_SP:     ctrl = C_SI;
      RET:        ctrl = C_RO | C_CI | C_CS;
      MOUT:       ctrl = C_RO | C_GO;
      ROUT:       ctrl = C_RFO | C_GO;
      SET_MAR:    ctrl = C_MI | C_DA;
      IRQ_SP:     ctrl = C_SO | C_MI;
      IRQ_PUSH:   ctrl = C_CO | C_RI | C_SI | C_SD;
      IRQ_VEC:    ctrl = C_VO | C_CI | C_CS;
      HALT:       ctrl = C_HALT;
      default:    ctrl = '0;
    endcase
  end

  always_comb begin
    vec_addr = IRQ_VECTOR;
    irq_ack  = (state_q == IRQ_VEC);
    illegal  = (state_q == DECODE) && (opcode > OP_DI) && (opcode != OP_HLT);
    state    = state_q;
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed vector bench for control_sequencer
module tb_control_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  opcode;
  logic [2:0]  operand_2;
  logic        flag_zero, flag_carry, mem_ready, irq;
  logic [19:0] ctrl;
  logic [7:0]  vec_addr;
  logic        irq_ack, illegal;
  logic [7:0]  state;

  int tests = 0;
  int fails = 0;

  localparam logic [7:0] FPC = 0, FI = 1, DEC = 2, FOPR = 3, AEX = 4, AOUT = 5, LA = 6, SR = 7,
                         SM = 8, MOV = 9, JMP = 10, FSP = 11, STK = 12, INC = 13, RET = 14,
                         MOUT = 15, ROUT = 16, SMAR = 17, ISP = 18, IPUSH = 19, IVEC = 20, HLT = 21;
  localparam logic [19:0] K_FPC = 20'h00106, K_FI = 20'h00201, K_AEX = 20'h00080, K_AOUT = 20'h00050,
                          K_LA = 20'h00300, K_SR = 20'h00210, K_SM = 20'h00420, K_MOV = 20'h00030,
                          K_JT = 20'h0020A, K_JN = 20'h00200, K_FSP = 20'h00900, K_STK = 20'h03420,
                          K_INC = 20'h02000, K_RET = 20'h0020A, K_MOUT = 20'h08200, K_ROUT = 20'h08020,
                          K_SMAR = 20'h10100, K_IPUSH = 20'h03404, K_IVEC = 20'h2000A, K_HLT = 20'h04000;

  typedef struct {
    logic        rst;
    logic [4:0]  op;
    logic [2:0]  o2;
    logic        fz, fc, mr, irq;
    logic [7:0]  st;
    logic [19:0] ctl;
    logic        ack, ill;
  } vec_t;

  vec_t tbl[$];

  control_sequencer dut (
    .clk(clk), .reset(reset), .opcode(opcode), .operand_2(operand_2),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .mem_ready(mem_ready), .irq(irq),
    .ctrl(ctrl), .vec_addr(vec_addr), .irq_ack(irq_ack), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic rst, logic [4:0] op, logic [2:0] o2, logic fz, logic fc,
                              logic mr, logic iq, logic [7:0] st, logic [19:0] ctl, logic ack, logic ill);
    vec_t v;
    v.rst = rst; v.op = op; v.o2 = o2; v.fz = fz; v.fc = fc; v.mr = mr; v.irq = iq;
    v.st = st; v.ctl = ctl; v.ack = ack; v.ill = ill;
    return v;
  endfunction

  function automatic vec_t s(logic [4:0] op, logic [7:0] st, logic [19:0] ctl);
    return mk(0, op, 0, 0, 0, 1, 0, st, ctl, 0, 0);
  endfunction

  function automatic vec_t si(logic [4:0] op, logic [7:0] st, logic [19:0] ctl, logic ack);
    return mk(0, op, 0, 0, 0, 1, 1, st, ctl, ack, 0);
  endfunction

  task automatic pre(input logic [4:0] op);
    tbl.push_back(s(op, FPC, K_FPC));
    tbl.push_back(s(op, FI, K_FI));
    tbl.push_back(s(op, DEC, 20'h0));
  endtask

  task automatic run(input vec_t v, input string nm);
    reset = v.rst; opcode = v.op; operand_2 = v.o2; flag_zero = v.fz; flag_carry = v.fc;
    mem_ready = v.mr; irq = v.irq;
    #1;
    tests++;
    if (state !== v.st || ctrl !== v.ctl || irq_ack !== v.ack || illegal !== v.ill || vec_addr !== 8'hF0) begin
      fails++;
      $display("FAIL %s: got state=%0d ctrl=%05h ack=%b ill=%b vec=%02h, want state=%0d ctrl=%05h ack=%b ill=%b vec=f0",
               nm, state, ctrl, irq_ack, illegal, vec_addr, v.st, v.ctl, v.ack, v.ill);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; opcode = 0; operand_2 = 0; flag_zero = 0; flag_carry = 0; mem_ready = 1; irq = 0;
    pre(0);
    pre(3);
    tbl.push_back(s(3, FOPR, K_FPC));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, LA, K_LA, 0, 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 0, 0, LA, K_LA, 0, 0));
    tbl.push_back(s(3, LA, K_LA));
    tbl.push_back(s(3, SR, K_SR));
    tbl.push_back(s(4, FPC, K_FPC));
    tbl.push_back(mk(0, 4, 0, 0, 0, 0, 0, FI, K_FI, 0, 0));
    tbl.push_back(s(4, FI, K_FI));
    tbl.push_back(s(4, DEC, 20'h0));
    tbl.push_back(mk(0, 4, 0, 0, 0, 0, 0, FOPR, K_FPC, 0, 0));
    tbl.push_back(s(4, LA, K_LA));
    tbl.push_back(mk(0, 4, 0, 0, 0, 0, 0, SM, K_SM, 0, 0));
    tbl.push_back(s(4, SM, K_SM));
    pre(5);
    tbl.push_back(s(5, MOV, K_MOV));
    pre(6);
    tbl.push_back(s(6, FOPR, K_FPC));
    tbl.push_back(mk(0, 6, 3, 1, 0, 1, 0, JMP, K_JT, 0, 0));
    pre(6);
    tbl.push_back(s(6, FOPR, K_FPC));
    tbl.push_back(mk(0, 6, 3, 0, 1, 1, 0, JMP, K_JN, 0, 0));
    pre(6);
    tbl.push_back(s(6, FOPR, K_FPC));
    tbl.push_back(mk(0, 6, 7, 1, 1, 1, 0, JMP, K_JN, 0, 0));
    pre(6);
    tbl.push_back(s(6, FOPR, K_FPC));
    tbl.push_back(mk(0, 6, 1, 0, 1, 1, 0, JMP, K_JT, 0, 0));
    pre(6);
    tbl.push_back(s(6, FOPR, K_FPC));
    tbl.push_back(mk(0, 6, 4, 1, 0, 1, 0, JMP, K_JN, 0, 0));
    pre(7);
    tbl.push_back(s(7, FSP, K_FSP));
    tbl.push_back(s(7, STK, K_STK));
    pre(8);
    tbl.push_back(s(8, INC, K_INC));
    tbl.push_back(s(8, FSP, K_FSP));
    tbl.push_back(s(8, RET, K_RET));
    pre(9);
    tbl.push_back(s(9, FOPR, K_FPC));
    tbl.push_back(s(9, LA, K_LA));
    tbl.push_back(s(9, MOUT, K_MOUT));
    pre(10);
    tbl.push_back(s(10, ROUT, K_ROUT));
    pre(11);
    tbl.push_back(s(11, SMAR, K_SMAR));
    tbl.push_back(s(11, SR, K_SR));
    pre(2);
    tbl.push_back(s(2, FOPR, K_FPC));
    tbl.push_back(s(2, SR, K_SR));
    tbl.push_back(s(20, FPC, K_FPC));
    tbl.push_back(s(20, FI, K_FI));
    tbl.push_back(mk(0, 20, 0, 0, 0, 1, 0, DEC, 20'h0, 0, 1));
    pre(12);
    tbl.push_back(si(1, FPC, K_FPC, 0));
    tbl.push_back(si(1, FI, K_FI, 0));
    tbl.push_back(si(1, DEC, 20'h0, 0));
    tbl.push_back(si(1, AEX, K_AEX, 0));
    tbl.push_back(si(1, AOUT, K_AOUT, 0));
    tbl.push_back(si(1, ISP, K_FSP, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, IPUSH, K_IPUSH, 0, 0));
    tbl.push_back(si(1, IPUSH, K_IPUSH, 0));
    tbl.push_back(si(1, IVEC, K_IVEC, 1));
    tbl.push_back(si(0, FPC, K_FPC, 0));
    tbl.push_back(si(0, FI, K_FI, 0));
    tbl.push_back(si(0, DEC, 20'h0, 0));
    tbl.push_back(si(0, FPC, K_FPC, 0));
    tbl.push_back(s(0, FI, K_FI));
    tbl.push_back(s(0, DEC, 20'h0));

    @(posedge clk);
    @(posedge clk);
    #1;
    for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("vec%0d", i));

    run(s(31, FPC, K_FPC), "hlt_fetch");
    run(s(31, FI, K_FI), "hlt_inst");
    run(s(31, DEC, 20'h0), "hlt_dec");
    for (int i = 0; i < 50; i++) run(mk(0, 31, 0, 0, 0, 1, i[0], HLT, K_HLT, 0, 0), $sformatf("halt_hold%0d", i));
    run(mk(1, 31, 0, 0, 0, 1, 0, HLT, K_HLT, 0, 0), "halt_reset");
    run(s(0, FPC, K_FPC), "after_reset");
    run(s(0, FI, K_FI), "ei_inst");
    run(s(12, DEC, 20'h0), "ei_dec");
    run(s(7, FPC, K_FPC), "push_fetch");
    run(s(7, FI, K_FI), "push_inst");
    run(s(7, DEC, 20'h0), "push_dec");
    run(s(7, FSP, K_FSP), "push_sp");
    run(mk(1, 7, 0, 0, 0, 0, 0, STK, K_STK, 0, 0), "stk_reset");
    run(si(0, FPC, K_FPC, 0), "stk_reset_fetch");
    run(si(0, FI, K_FI, 0), "ie_clr_inst");
    run(si(0, DEC, 20'h0, 0), "ie_clr_dec");
    run(s(12, FPC, K_FPC), "ie_clr_boundary");
    run(s(12, FI, K_FI), "ei2_inst");
    run(s(12, DEC, 20'h0), "ei2_dec");
    run(s(31, FPC, K_FPC), "hlt2_fetch");
    run(s(31, FI, K_FI), "hlt2_inst");
    run(s(31, DEC, 20'h0), "hlt2_dec");
    run(s(31, HLT, K_HLT), "hlt2_hold0");
    run(s(31, HLT, K_HLT), "hlt2_hold1");
    run(si(31, HLT, K_HLT, 0), "hlt2_irq");
    run(si(31, ISP, K_FSP, 0), "hlt2_isp");
    run(si(31, IPUSH, K_IPUSH, 0), "hlt2_ipush");
    run(si(31, IVEC, K_IVEC, 1), "hlt2_ivec");
    run(si(0, FPC, K_FPC, 0), "hlt2_resume");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Next-generation control unit for the CoCC CPU: a registered micro-step sequencer replacing the purely combinational state-to-signal decoder.
- Owns the state register and decodes the instruction register fields into the next state.
- Adds a memory-wait handshake, a vectored maskable interrupt, halt-resume and illegal-opcode detection.
- Drives the existing datapath control strobes from registered state only (Moore outputs), apart from the flag-qualified jump strobes.

Parameters:
- OPC_W, 5, opcode field width.
- SEL_W, 3, operand_1 / operand_2 field width.
- ADDR_W, 8, address bus width.
- IRQ_VECTOR, 8'hF0, interrupt handler address, width ADDR_W.

Ports:
- clk  in  1  system clock; everything sampled on its rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  OPC_W  IR opcode field.
- operand_2  in  SEL_W  jump-condition select.
- flag_zero  in  1  ALU zero flag.
- flag_carry  in  1  ALU carry flag.
- mem_ready  in  1  RAM handshake; 0 stretches the current RAM step.
- irq  in  1  level interrupt request.
- ctrl  out  20  control strobes: [0]ii [1]ci [2]co [3]cs [4]rfi [5]rfo [6]eo [7]ee [8]mi [9]ro [10]ri [11]so [12]sd [13]si [14]halt [15]go [16]da [17]vo.
- vec_addr  out  ADDR_W  constant IRQ_VECTOR; put on the bus while vo=1.
- irq_ack  out  1  one-cycle pulse on entering IRQ_VEC.
- illegal  out  1  one-cycle pulse on decoding an undefined opcode.
- state  out  8  current state, for debug.

Behaviour:
- Reset: state=FETCH_PC, ie=0, irq_ack=0, illegal=0. ctrl then shows the FETCH_PC strobes only. Reset takes effect from any state, mid-instruction included.
- Opcode decoding happens in DECODE (no strobes). Strobes per state:
  - FETCH_PC: co, mi, ci.
  - FETCH_INST: ro, ii.
  - FETCH_OPR: co, mi, ci.
  - ALU_EXEC: ee.
  - ALU_OUT: eo, rfi.
  - LOAD_ADDR: ro, mi.
  - SET_REG: ro, rfi.
  - SET_MEM: rfo, ri.
  - MOVE_REG: rfo, rfi.
  - JUMP: ro always; ci and cs only when ja.
  - FETCH_SP: so, mi.
  - STACK_REG: rfo, ri, si, sd.
  - INC_SP: si.
  - RET: ro, ci, cs.
  - MOUT: ro, go.
  - ROUT: rfo, go.
  - SET_MAR: mi, da.
  - IRQ_SP: so, mi.
  - IRQ_PUSH: co, ri, si, sd.
  - IRQ_VEC: vo, ci, cs.
  - HALT: halt.
- Jump condition ja, by operand_2: 0=JMP always, 1=JC carry, 2=JNC ~carry, 3=JZ zero, 4=JNZ ~zero, other values never. Flags are sampled in the JUMP cycle.
- Flow: FETCH_PC -> FETCH_INST -> DECODE -> opcode path -> FETCH_PC.
- Opcode paths after DECODE:
  - 0 NOP: none.
  - 1 ALU: ALU_EXEC, ALU_OUT.
  - 2 LDI: FETCH_OPR, SET_REG.
  - 3 LD: FETCH_OPR, LOAD_ADDR, SET_REG.
  - 4 ST: FETCH_OPR, LOAD_ADDR, SET_MEM.
  - 5 MOV: MOVE_REG.
  - 6 JMP family: FETCH_OPR, JUMP.
  - 7 PUSH: FETCH_SP, STACK_REG.
  - 8 RET/POP-PC: INC_SP, FETCH_SP, RET.
  - 9 MOUT: FETCH_OPR, LOAD_ADDR, MOUT.
  - 10 ROUT: ROUT.
  - 11 LDR: SET_MAR, SET_REG.
  - 12 EI: sets ie.
  - 13 DI: clears ie.
  - all-ones HLT: HALT.
  - All other opcodes: pulse illegal, execute as NOP.
- FETCH_SP is shared; its successor is chosen from the held opcode (7 -> STACK_REG, 8 -> RET).
- Wait handshake: in any state asserting ro or ri, if mem_ready=0 the state holds and all strobes stay asserted. Advance occurs on the first cycle with mem_ready=1. States without ro/ri ignore mem_ready.
- Interrupt check: made only where FETCH_PC would be entered (end of any instruction), and also in HALT.
  - If irq & ie: go to IRQ_SP -> IRQ_PUSH -> IRQ_VEC -> FETCH_PC instead.
  - ie is cleared on entering IRQ_SP.
  - irq_ack is high during the IRQ_VEC cycle.
  - EI takes effect on the next instruction boundary.
- HALT: holds with halt=1 until reset, or until irq & ie, which takes the interrupt path. The return from that interrupt resumes after HLT.
- Latency:
  - NOP: 3 cycles.
  - LD: 6 cycles.
  - Interrupt entry: 3 cycles plus any memory waits.
- No strobe combination depends on irq within a state. The strobes are a function of state plus flags and operand_2 (JUMP only).

Test Plan:
- Reset then NOP (opcode 0), mem_ready=1 -> states FETCH_PC, FETCH_INST, DECODE, FETCH_PC. ctrl=0x00106, then 0x00201, then 0.
- LD (opcode 3) with mem_ready low for 2 cycles in LOAD_ADDR -> LOAD_ADDR held 3 cycles with ro,mi steady. SET_REG follows; 8 cycles total.
- JZ (opcode 6, operand_2=3): flag_zero=1 -> JUMP has ro,ci,cs. flag_zero=0 -> JUMP has ro only. operand_2=7 -> never taken.
- EI, then irq=1 during an ALU instruction -> ALU completes, then IRQ_SP, IRQ_PUSH, IRQ_VEC. irq_ack=1 for exactly one cycle, vec_addr=8'hF0, ie=0 afterwards. With ie=0, irq is ignored.
- HLT with ie=0 -> halt stays 1 for 50 cycles. Assert reset for 1 cycle -> FETCH_PC next cycle, ctrl=0x00106.
- Opcode 20 -> illegal pulses 1 cycle in DECODE, next state FETCH_PC. Reset asserted in STACK_REG -> FETCH_PC, ie=0.
